// File: rtl/veda_mem_initiator.sv
// Single-word request sequencer for the Veda 32x32 register memory port.
// Define VEDA_INIT_SCRUB_EN to zero the whole memory after every reset release.
module veda_mem_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic [ADDR_W-1:0] mem_address_b,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_data_out
);

  // Companion address differs in bit 0 so the memory's a!=b guard never blocks us.
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    CAPTURE,
    RESP
`ifdef VEDA_INIT_SCRUB_EN
    , SCRUB
`endif
  } state_t;

`ifdef VEDA_INIT_SCRUB_EN
  localparam state_t RESET_STATE = SCRUB;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  logic [ADDR_W-1:0] scrub_addr, scrub_addr_d;
  logic              scrub_active, scrub_active_d;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state, state_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_data_d;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;
  logic [DATA_W-1:0] data_in_d;
  logic              we_d, mode_d;

  // NOTE: every output of this block gets a default first, so no path through the case leaves a latch.
  always_comb begin
    state_d      = state;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    addr_a_d     = mem_address_a;
    addr_b_d     = mem_address_b;
    data_in_d    = mem_data_in;
    we_d         = mem_write_enable;
    mode_d       = mem_mode;
`ifdef VEDA_INIT_SCRUB_EN
    scrub_addr_d   = scrub_addr;
    scrub_active_d = scrub_active;
`endif
    unique case (state)
      IDLE: begin
        we_d   = 1'b0;
        mode_d = 1'b0;
        if (req_valid && req_ready) begin
          if (req_write) begin
            addr_a_d  = req_addr;
            addr_b_d  = req_addr ^ ADDR_ONE;
            data_in_d = req_wdata;
            we_d      = 1'b1;
            state_d   = ISSUE_WR;
          end else begin
            addr_b_d = req_addr;
            addr_a_d = req_addr ^ ADDR_ONE;
            mode_d   = 1'b1;
            state_d  = ISSUE_RD;
          end
        end
      end
      ISSUE_WR: begin
        we_d    = 1'b0;
        mode_d  = 1'b0;
        state_d = IDLE;
`ifdef VEDA_INIT_SCRUB_EN
        if (scrub_active) begin
          if (scrub_addr == ADDR_MAX) begin
            scrub_active_d = 1'b0;
          end else begin
            scrub_addr_d = scrub_addr + ADDR_ONE;
            state_d      = SCRUB;
          end
        end
`endif
      end
      ISSUE_RD: begin
        mode_d  = 1'b0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        resp_data_d  = mem_data_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
`ifdef VEDA_INIT_SCRUB_EN
      SCRUB: begin
        addr_a_d  = scrub_addr;
        addr_b_d  = scrub_addr ^ ADDR_ONE;
        data_in_d = '0;
        we_d      = 1'b1;
        mode_d    = 1'b0;
        state_d   = ISSUE_WR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= RESET_STATE;
      req_ready        <= 1'b0;
      busy             <= 1'b1;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      mem_address_a    <= '0;
      mem_address_b    <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
      mem_mode         <= 1'b0;
`ifdef VEDA_INIT_SCRUB_EN
      scrub_addr       <= '0;
      scrub_active     <= 1'b1;
`endif
    end else begin
      state            <= state_d;
      req_ready        <= (state_d == IDLE);
      busy             <= (state_d != IDLE);
      resp_valid       <= resp_valid_d;
      resp_data        <= resp_data_d;
      mem_address_a    <= addr_a_d;
      mem_address_b    <= addr_b_d;
      mem_data_in      <= data_in_d;
      mem_write_enable <= we_d;
      mem_mode         <= mode_d;
`ifdef VEDA_INIT_SCRUB_EN
      scrub_addr       <= scrub_addr_d;
      scrub_active     <= scrub_active_d;
`endif
    end
  end

endmodule

// File: tb/tb_veda_mem_initiator.sv
// Directed bench for veda_mem_initiator with a behavioural Veda memory model attached.
module tb_veda_mem_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, busy, mem_write_enable, mem_mode;
  logic [31:0] resp_data, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [4:0]  mem_address_a, mem_address_b;

  int total = 0;
  int bad   = 0;
  int wr_count = 0;
  logic [31:0] mem [32];

  veda_mem_initiator #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy),
    .mem_address_a(mem_address_a), .mem_address_b(mem_address_b),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_mode(mem_mode), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: write in mode 0 with enable, registered read in mode 1, both need a != b.
  always @(posedge clk) begin
    if (!mem_mode && mem_write_enable && mem_address_a != mem_address_b) begin
      mem[mem_address_a] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
    if (mem_mode && mem_address_a != mem_address_b)
      mem_data_out <= mem[mem_address_b];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until req_ready rises, capped at budget.
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!req_ready && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic accept(input logic wr, input logic [4:0] a, input logic [31:0] d);
    int n;
    wait_ready(200, n);
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    accept(1'b1, a, d);
    check("wr_addr_a", {27'b0, mem_address_a}, {27'b0, a});
    check("wr_addr_b", {27'b0, mem_address_b}, {27'b0, a ^ 5'd1});
    check("wr_data", mem_data_in, d);
    check("wr_we_mode", {30'b0, mem_write_enable, mem_mode}, 32'b10);
    check("wr_busy_rdy", {30'b0, busy, req_ready}, 32'b10);
    tick();
    check("wr_done", {30'b0, mem_write_enable, req_ready}, 32'b01);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [31:0] exp);
    int lat;
    resp_ready = 1'b1;
    accept(1'b0, a, 32'h0);
    check("rd_addr_b", {27'b0, mem_address_b}, {27'b0, a});
    check("rd_addr_a", {27'b0, mem_address_a}, {27'b0, a ^ 5'd1});
    check("rd_we_mode", {30'b0, mem_write_enable, mem_mode}, 32'b01);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("rd_latency", lat, 32'd3);
    check("rd_data", resp_data, exp);
    tick();
    check("rd_valid_drop", {30'b0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int n;
    int wr_before;
    logic seen;
    logic [31:0] exp7;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + i;

    // Reset held low for three cycles.
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mem", {mem_address_a, mem_address_b, mem_write_enable, mem_mode} , 32'h0);
      check("rst_data", mem_data_in | resp_data, 32'h0);
      check("rst_flags", {29'b0, resp_valid, busy, req_ready}, 32'b010);
    end
    reset = 1'b1;
`ifdef VEDA_INIT_SCRUB_EN
    wait_ready(200, n);
    check("scrub_len", n, 32'd64);
`else
    tick();
    check("rel_ready", {30'b0, req_ready, busy}, 32'b10);
`endif

    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 32'hDEADBEEF);

    do_write(5'd31, 32'h1);
    do_write(5'd0, 32'h2);
    do_read(5'd31, 32'h1);
    do_read(5'd0, 32'h2);

    // Response held off: output must stay stable and stray requests ignored.
    do_write(5'd7, 32'h77);
    wr_before = wr_count;
    resp_ready = 1'b0;
    accept(1'b0, 5'd7, 32'h0);
    n = 0;
    while (!resp_valid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_wdata = 32'hBAD0BAD0;
      end
      tick();
      req_valid = 1'b0;
      check("hold_valid", {30'b0, resp_valid, req_ready}, 32'b10);
      check("hold_data", resp_data, 32'h77);
    end
    check("hold_no_write", wr_count, wr_before);
    resp_ready = 1'b1;
    tick();
    check("hold_release", {30'b0, resp_valid, req_ready}, 32'b01);
    do_read(5'd3, 32'hA5A5_0003);

    // Reset during ISSUE_RD abandons the read.
    wr_before = wr_count;
    accept(1'b0, 5'd7, 32'h0);
    #2 reset = 1'b0;
    #1 check("mid_rst", {28'b0, resp_valid, req_ready, busy, mem_write_enable}, 32'b0010);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (resp_valid) seen = 1'b1;
    end
    check("mid_rst_no_resp", {31'b0, seen}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
`ifdef VEDA_INIT_SCRUB_EN
    exp7 = 32'h0;
`else
    exp7 = 32'h77;
    check("mid_rst_no_write", wr_count, wr_before);
`endif
    do_read(5'd7, exp7);

`ifdef VEDA_INIT_SCRUB_EN
    do_write(5'd17, 32'h1717);
    do_write(5'd31, 32'h3131);
    do_write(5'd0, 32'h5);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_ready(200, n);
    check("scrub_len2", n, 32'd64);
    do_read(5'd0, 32'h0);
    do_read(5'd17, 32'h0);
    do_read(5'd31, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/veda_mem_initiator.md
Name: veda_mem_initiator

Overview:
- Initiator/controller that drives the Veda 32x32 register memory port: address_a, address_b, data_in, write_enable, mode and data_out.
- Accepts single-word read/write requests from a host over a valid/ready handshake.
- Sequences the memory's mode/enable/address-conflict rules, then returns read data over a valid/ready response channel.
- Sits between the datapath/testbench host and the Veda memory instance.

Parameters:
- ADDR_W, 5, memory address width; depth is 2**ADDR_W.
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  host request valid.
- req_ready  output  1  initiator can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- resp_valid  output  1  read data available.
- resp_ready  input  1  host accepts read data.
- resp_data  output  DATA_W  read data.
- busy  output  1  1 whenever state != IDLE.
- mem_address_a  output  ADDR_W  memory write address.
- mem_address_b  output  ADDR_W  memory read address.
- mem_data_in  output  DATA_W  memory write data.
- mem_write_enable  output  1  memory write enable.
- mem_mode  output  1  0 = write mode, 1 = read mode.
- mem_data_out  input  DATA_W  registered memory read data.

Behaviour:
- Reset values (async, while reset==0): all mem_* outputs = 0, resp_data = 0, resp_valid = 0, busy = 1, req_ready = 0, state = IDLE (or SCRUB, see Optional Feature).
  - busy is forced 1 during reset.
  - After reset deasserts, busy/req_ready follow the FSM.
- All outputs are registered.
  - req_ready = (state==IDLE), registered equivalent.
  - busy = (state!=IDLE).
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, CAPTURE, RESP.
- IDLE:
  - Drives mem_write_enable=0, mem_mode=0.
  - On req_valid && req_ready, latches the command and loads the mem_* registers on that edge.
  - Write: mem_address_a=req_addr, mem_address_b=req_addr^1, mem_data_in=req_wdata, mem_write_enable=1, mem_mode=0; go to ISSUE_WR.
  - Read: mem_address_b=req_addr, mem_address_a=req_addr^1, mem_write_enable=0, mem_mode=1; go to ISSUE_RD.
  - The companion address always differs from the target in bit 0, so the memory's address_a!=address_b guard never suppresses an access.
- ISSUE_WR:
  - Memory commits on this cycle's closing edge.
  - Same edge: mem_write_enable=0, mem_mode=0; go to IDLE.
  - Write occupancy is 2 cycles; next accept is possible 2 cycles after the previous one.
- ISSUE_RD:
  - Memory registers data_out on the closing edge.
  - Same edge: mem_mode=0; go to CAPTURE.
- CAPTURE:
  - resp_data <= mem_data_out, resp_valid <= 1; go to RESP.
  - Read latency is 3 edges from accept to resp_valid high.
- RESP:
  - Hold resp_data and resp_valid stable until resp_ready.
  - On the resp_ready edge: resp_valid <= 0; go to IDLE.
  - req_ready is 0 throughout, so there is no overlap of requests.
- A request is never dropped once accepted; req_* inputs are ignored outside IDLE.
- Reset asserted mid-operation: the in-flight request is abandoned, resp_valid drops immediately, and no memory write is issued after release.
- Address wrap: req_addr = 2**ADDR_W-1 gives companion address 2**ADDR_W-2; address 0 gives companion 1. No special case is needed.

Optional Feature:
- Macro VEDA_INIT_SCRUB_EN.
- Defined:
  - After reset release, the FSM enters SCRUB and writes 0 to addresses 0..2**ADDR_W-1 in order, 2 cycles per address, using the same write sequencing.
  - During SCRUB: req_ready=0, busy=1; 2*2**ADDR_W cycles total (64 at default), then IDLE.
  - Reset during SCRUB restarts the scrub from address 0.
- Undefined: no SCRUB state; the FSM goes straight to IDLE after reset release.

Test Plan:
- Reset low for 3 cycles, then high -> all mem_* outputs = 0 and resp_valid = 0 while reset is low; req_ready = 1 one cycle after release (scrub disabled).
- Write addr 5, data 0xDEADBEEF, then read addr 5 with resp_ready=1 -> mem_address_a=5, mem_address_b=4 during write; resp_data = 0xDEADBEEF with resp_valid high 3 edges after the read accept.
- Write addr 31 = 0x1, write addr 0 = 0x2, read 31, read 0 -> responses 0x1 then 0x2; companion addresses 30 and 1 respectively.
- Read addr 7 with resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, req_ready = 0; a req_valid pulse in that window is ignored (no mem access).
- Read accepted, reset pulsed low during ISSUE_RD -> resp_valid never rises; after release, req_ready returns and no write occurred (readback of address 7 unchanged).
- With VEDA_INIT_SCRUB_EN: preload memory nonzero, then reset -> req_ready = 0 for 64 cycles; afterwards reads of addresses 0, 17 and 31 all return 0.
